// File: rtl/input_control.sv
// 4x4 matrix-keypad front end for the 16-bit signed calculator.
// Scans the columns, debounces press and release against an external
// LFSR interval timer, decodes the key and hands it to the calculator
// controller through a KeyRdy/KeyRd handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   SCAN     | rotating the column drive, waiting for any row low
//   DB_PRESS | column frozen, waiting out the press bounce interval
//   WAIT_REL | key decoded, waiting for all rows to go high
//   DB_REL   | waiting out the release bounce interval
//   READY    | decoded key presented, waiting for KeyRd
module input_control (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] RowIn,
  output logic [3:0] ColOut,
  output logic       LFSRReset,
  input  logic       LFSRFlg,
  output logic       KeyRdy,
  input  logic       KeyRd,
  output logic [3:0] Number,
  output logic [2:0] Operator,
  output logic       EqualSign
);

  localparam logic [2:0] SCAN     = 3'd0;
  localparam logic [2:0] DB_PRESS = 3'd1;
  localparam logic [2:0] WAIT_REL = 3'd2;
  localparam logic [2:0] DB_REL   = 3'd3;
  localparam logic [2:0] READY    = 3'd4;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_CLR   = 3'b101;

  logic [2:0] state;
  logic [1:0] col_idx;
  logic [1:0] row_idx;
  logic [1:0] first_row;
  logic       all_up;
  logic       row_held;
  logic       flg_valid;
  logic [3:0] dec_number;
  logic [2:0] dec_operator;
  logic       dec_equal;

  assign all_up    = (RowIn == 4'b1111);
  assign row_held  = ~RowIn[row_idx];
  // The timer flag is stale in the cycle its restart pulse is still high.
  assign flg_valid = LFSRFlg & ~LFSRReset;
  // Column drive is a one-cold decode of the column index, so exactly one
  // bit is low by construction.
  assign ColOut    = ~(4'b0001 << col_idx);

  // Lowest-index closed row wins when several rows are low.
  always_comb begin
    first_row = 2'd3;
    if (!RowIn[0])      first_row = 2'd0;
    else if (!RowIn[1]) first_row = 2'd1;
    else if (!RowIn[2]) first_row = 2'd2;
  end

  // Key map lookup from the latched row and column.
  always_comb begin
    dec_number   = 4'd0;
    dec_operator = OP_NONE;
    dec_equal    = 1'b0;
    case ({row_idx, col_idx})
      4'b00_00: dec_number   = 4'd1;
      4'b00_01: dec_number   = 4'd2;
      4'b00_10: dec_number   = 4'd3;
      4'b00_11: dec_operator = OP_ADD;
      4'b01_00: dec_number   = 4'd4;
      4'b01_01: dec_number   = 4'd5;
      4'b01_10: dec_number   = 4'd6;
      4'b01_11: dec_operator = OP_SUB;
      4'b10_00: dec_number   = 4'd7;
      4'b10_01: dec_number   = 4'd8;
      4'b10_10: dec_number   = 4'd9;
      4'b10_11: dec_operator = OP_MUL;
      4'b11_00: dec_operator = OP_CLR;
      4'b11_01: dec_number   = 4'd0;
      4'b11_10: dec_equal    = 1'b1;
      4'b11_11: dec_operator = OP_DIV;
      default:  dec_number   = 4'd0;
    endcase
  end

  // Scan / debounce / handshake sequencer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      LFSRReset <= 1'b0;
      KeyRdy    <= 1'b0;
      Number    <= 4'd0;
      Operator  <= OP_NONE;
      EqualSign <= 1'b0;
    end else begin
      LFSRReset <= 1'b0;
      case (state)
        SCAN: begin
          if (all_up) begin
            col_idx <= col_idx + 2'd1;
          end else begin
            row_idx   <= first_row;
            LFSRReset <= 1'b1;
            state     <= DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (flg_valid) begin
            if (row_held) begin
              Number    <= dec_number;
              Operator  <= dec_operator;
              EqualSign <= dec_equal;
              state     <= WAIT_REL;
            end else begin
              state <= SCAN;
            end
          end
        end
        WAIT_REL: begin
          if (all_up) begin
            LFSRReset <= 1'b1;
            state     <= DB_REL;
          end
        end
        DB_REL: begin
          if (flg_valid) begin
            if (all_up) begin
              KeyRdy <= 1'b1;
              state  <= READY;
            end else begin
              state <= WAIT_REL;
            end
          end
        end
        READY: begin
          // Column index is left alone so scanning resumes from this key.
          if (KeyRd) begin
            KeyRdy <= 1'b0;
            state  <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_input_control.sv
// Directed bench for the keypad front end: a per-cycle vector table from
// reset through one full digit transaction, a key-map table covering every
// key, and hand-written bounce / handshake / reset sequences.
module tb_input_control;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] RowIn;
  logic [3:0] ColOut;
  logic       LFSRReset;
  logic       LFSRFlg;
  logic       KeyRdy;
  logic       KeyRd;
  logic [3:0] Number;
  logic [2:0] Operator;
  logic       EqualSign;

  int checks = 0;
  int passes = 0;
  int rises = 0;
  int lr_double = 0;
  logic prev_rdy = 1'b0;
  logic prev_lr = 1'b0;

  input_control dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .RowIn     (RowIn),
    .ColOut    (ColOut),
    .LFSRReset (LFSRReset),
    .LFSRFlg   (LFSRFlg),
    .KeyRdy    (KeyRdy),
    .KeyRd     (KeyRd),
    .Number    (Number),
    .Operator  (Operator),
    .EqualSign (EqualSign)
  );

  always #5 Clock = ~Clock;

  // Count KeyRdy assertions and back-to-back LFSRReset highs.
  always @(negedge Clock) begin
    if (KeyRdy === 1'b1 && prev_rdy !== 1'b1) rises++;
    if (LFSRReset === 1'b1 && prev_lr === 1'b1) lr_double++;
    prev_rdy = KeyRdy;
    prev_lr  = LFSRReset;
  end

  typedef struct packed {
    logic [3:0] row;
    logic       flg;
    logic       rd;
    logic [3:0] col;
    logic       lr;
    logic       rdy;
    logic [3:0] num;
    logic [2:0] op;
    logic       eq;
  } vec_t;

  typedef struct packed {
    logic [1:0] col;
    logic [3:0] rmask;
    logic [3:0] num;
    logic [2:0] op;
    logic       eq;
  } key_t;

  vec_t vecs[15];
  key_t keys[17];

  function automatic vec_t mk(input logic [3:0] row, input logic flg, input logic rd,
                              input logic [3:0] col, input logic lr, input logic rdy,
                              input logic [3:0] num, input logic [2:0] op, input logic eq);
    vec_t v;
    v.row = row; v.flg = flg; v.rd = rd;
    v.col = col; v.lr = lr; v.rdy = rdy; v.num = num; v.op = op; v.eq = eq;
    return v;
  endfunction

  function automatic key_t mkk(input logic [1:0] col, input logic [3:0] rmask,
                               input logic [3:0] num, input logic [2:0] op, input logic eq);
    key_t k;
    k.col = col; k.rmask = rmask; k.num = num; k.op = op; k.eq = eq;
    return k;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Let the scan rotate until the wanted column is driven (bounded).
  task automatic wait_col(input logic [3:0] target, input string name);
    for (int n = 0; n < 8 && ColOut !== target; n++) step();
    check(name, 16'(ColOut), 16'(target));
  endtask

  initial begin
    logic [3:0] tcol;
    logic [3:0] one;
    int rises_start;

    // row  flg rd | col     lr rdy num op     eq
    vecs[0]  = mk(4'hF, 1, 0, 4'b1101, 0, 0, 4'd0, 3'b000, 0);
    vecs[1]  = mk(4'hF, 1, 0, 4'b1011, 0, 0, 4'd0, 3'b000, 0);
    vecs[2]  = mk(4'hF, 1, 0, 4'b0111, 0, 0, 4'd0, 3'b000, 0);
    vecs[3]  = mk(4'hF, 1, 0, 4'b1110, 0, 0, 4'd0, 3'b000, 0);
    vecs[4]  = mk(4'hF, 1, 0, 4'b1101, 0, 0, 4'd0, 3'b000, 0);
    vecs[5]  = mk(4'hE, 1, 0, 4'b1101, 1, 0, 4'd0, 3'b000, 0);
    vecs[6]  = mk(4'hE, 1, 0, 4'b1101, 0, 0, 4'd0, 3'b000, 0);
    vecs[7]  = mk(4'hE, 1, 0, 4'b1101, 0, 0, 4'd2, 3'b000, 0);
    vecs[8]  = mk(4'hE, 1, 0, 4'b1101, 0, 0, 4'd2, 3'b000, 0);
    vecs[9]  = mk(4'hF, 1, 0, 4'b1101, 1, 0, 4'd2, 3'b000, 0);
    vecs[10] = mk(4'hF, 1, 0, 4'b1101, 0, 0, 4'd2, 3'b000, 0);
    vecs[11] = mk(4'hF, 1, 0, 4'b1101, 0, 1, 4'd2, 3'b000, 0);
    vecs[12] = mk(4'hF, 1, 1, 4'b1101, 0, 0, 4'd2, 3'b000, 0);
    vecs[13] = mk(4'hF, 1, 0, 4'b1011, 0, 0, 4'd2, 3'b000, 0);
    vecs[14] = mk(4'hF, 1, 1, 4'b0111, 0, 0, 4'd2, 3'b000, 0);

    //               col  rmask    num   op      eq
    keys[0]  = mkk(2'd0, 4'b1110, 4'd1, 3'b000, 0);
    keys[1]  = mkk(2'd1, 4'b1110, 4'd2, 3'b000, 0);
    keys[2]  = mkk(2'd2, 4'b1110, 4'd3, 3'b000, 0);
    keys[3]  = mkk(2'd3, 4'b1110, 4'd0, 3'b001, 0);
    keys[4]  = mkk(2'd0, 4'b1101, 4'd4, 3'b000, 0);
    keys[5]  = mkk(2'd1, 4'b1101, 4'd5, 3'b000, 0);
    keys[6]  = mkk(2'd2, 4'b1101, 4'd6, 3'b000, 0);
    keys[7]  = mkk(2'd3, 4'b1101, 4'd0, 3'b010, 0);
    keys[8]  = mkk(2'd0, 4'b1011, 4'd7, 3'b000, 0);
    keys[9]  = mkk(2'd1, 4'b1011, 4'd8, 3'b000, 0);
    keys[10] = mkk(2'd2, 4'b1011, 4'd9, 3'b000, 0);
    keys[11] = mkk(2'd1, 4'b0111, 4'd0, 3'b000, 0);
    keys[12] = mkk(2'd3, 4'b1011, 4'd0, 3'b011, 0);
    keys[13] = mkk(2'd2, 4'b0111, 4'd0, 3'b000, 1);
    keys[14] = mkk(2'd0, 4'b0111, 4'd0, 3'b101, 0);
    keys[15] = mkk(2'd3, 4'b0111, 4'd0, 3'b100, 0);
    keys[16] = mkk(2'd0, 4'b1001, 4'd4, 3'b000, 0);

    // Reset state.
    Reset = 1'b1; RowIn = 4'hF; LFSRFlg = 1'b1; KeyRd = 1'b0;
    step();
    check("reset_state", 16'({ColOut, LFSRReset, KeyRdy, Number, Operator, EqualSign}),
          16'({4'b1110, 1'b0, 1'b0, 4'd0, 3'b000, 1'b0}));
    Reset = 1'b0;

    // Rotation plus one full '2' transaction, cycle by cycle.
    for (int i = 0; i < 15; i++) begin
      RowIn = vecs[i].row; LFSRFlg = vecs[i].flg; KeyRd = vecs[i].rd;
      step();
      check($sformatf("vec[%0d]", i),
            16'({ColOut, LFSRReset, KeyRdy, Number, Operator, EqualSign}),
            16'({vecs[i].col, vecs[i].lr, vecs[i].rdy, vecs[i].num, vecs[i].op, vecs[i].eq}));
    end
    KeyRd = 1'b0; RowIn = 4'hF;

    // Every key in the map, with the timer flag tied high.
    one = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      LFSRFlg = 1'b1; KeyRd = 1'b0; RowIn = 4'hF;
      tcol = ~(one << keys[k].col);
      wait_col(tcol, $sformatf("key[%0d]_col", k));
      RowIn = keys[k].rmask;
      step();
      check($sformatf("key[%0d]_press_pulse", k), 16'(LFSRReset), 16'(1));
      step();
      step();
      check($sformatf("key[%0d]_decode", k), 16'({Number, Operator, EqualSign}),
            16'({keys[k].num, keys[k].op, keys[k].eq}));
      RowIn = 4'hF;
      step();
      step();
      step();
      check($sformatf("key[%0d]_ready", k),
            16'({KeyRdy, ColOut, Number, Operator, EqualSign}),
            16'({1'b1, tcol, keys[k].num, keys[k].op, keys[k].eq}));
      KeyRd = 1'b1;
      step();
      KeyRd = 1'b0;
      check($sformatf("key[%0d]_ack", k), 16'(KeyRdy), 16'(0));
    end

    // Bounce on press: short closure, flag arrives after the row reopened.
    LFSRFlg = 1'b0;
    wait_col(4'b1110, "bp_col");
    RowIn = 4'b1110;
    step();
    check("bp_pulse", 16'(LFSRReset), 16'(1));
    RowIn = 4'hF;
    step();
    step();
    step();
    check("bp_hold", 16'({ColOut, LFSRReset, KeyRdy}), 16'({4'b1110, 1'b0, 1'b0}));
    LFSRFlg = 1'b1;
    step();
    check("bp_abort", 16'({ColOut, KeyRdy, Number, Operator, EqualSign}),
          16'({4'b1110, 1'b0, 4'd4, 3'b000, 1'b0}));
    step();
    check("bp_rescan", 16'(ColOut), 16'(4'b1101));

    // Bounce on release: re-closure inside the release interval.
    rises_start = rises;
    wait_col(4'b1101, "br_col");
    RowIn = 4'b1101;
    step();
    step();
    step();
    check("br_decode", 16'(Number), 16'(5));
    LFSRFlg = 1'b0;
    RowIn = 4'hF;
    step();
    check("br_rel_pulse", 16'(LFSRReset), 16'(1));
    RowIn = 4'b1101;
    step();
    check("br_reclose", 16'({LFSRReset, KeyRdy}), 16'(0));
    step();
    LFSRFlg = 1'b1;
    step();
    check("br_back_wait", 16'({LFSRReset, KeyRdy}), 16'(0));
    step();
    check("br_still_wait", 16'({LFSRReset, KeyRdy}), 16'(0));
    RowIn = 4'hF;
    step();
    check("br_rel2_pulse", 16'(LFSRReset), 16'(1));
    step();
    step();
    check("br_ready", 16'({KeyRdy, Number}), 16'({1'b1, 4'd5}));

    // Held in READY without acknowledge; key activity must be ignored.
    for (int i = 0; i < 50; i++) begin
      RowIn = i[0] ? 4'b1110 : 4'hF;
      LFSRFlg = i[1];
      step();
      check($sformatf("hold[%0d]", i),
            16'({KeyRdy, LFSRReset, ColOut, Number, Operator, EqualSign}),
            16'({1'b1, 1'b0, 4'b1101, 4'd5, 3'b000, 1'b0}));
    end
    check("br_single_rdy", 16'(rises - rises_start), 16'(1));

    // Reset from READY.
    RowIn = 4'hF; LFSRFlg = 1'b1;
    Reset = 1'b1;
    step();
    check("ready_reset", 16'({ColOut, LFSRReset, KeyRdy, Number, Operator, EqualSign}),
          16'({4'b1110, 1'b0, 1'b0, 4'd0, 3'b000, 1'b0}));
    Reset = 1'b0;
    step();
    check("post_reset_scan", 16'(ColOut), 16'(4'b1101));
    check("lfsr_reset_single", 16'(lr_double), 16'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/input_control.md
Name: input_control

Overview:
- 4x4 matrix-keypad front end for the 16-bit signed calculator.
- Scans the columns, debounces press and release using an external LFSR interval timer (LFSRReset/LFSRFlg), and decodes the key into a digit, an operator or an equals flag.
- Presents the decoded key to the downstream calculator controller through a KeyRdy/KeyRd handshake.

Parameters:
- None. Keypad is fixed at 4x4.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- RowIn  input  4  keypad rows, active-low; RowIn[r]=0 means a key in row r of the driven column is closed.
- ColOut  output  4  column drive, active-low, exactly one bit low at all times.
- LFSRReset  output  1  one-cycle pulse that restarts the external debounce timer.
- LFSRFlg  input  1  high when the debounce interval has elapsed since the last LFSRReset.
- KeyRdy  output  1  decoded key valid.
- KeyRd  input  1  consumer acknowledge.
- Number  output  4  digit value 0-9; 0 for non-digit keys.
- Operator  output  3  000 none, 001 add, 010 sub, 011 mul, 100 div, 101 clear.
- EqualSign  output  1  1 when the key is '='.

Behaviour:
- Key map, row r / column c, giving ColOut low bit c and RowIn low bit r:
  - r0: 1 2 3 +
  - r1: 4 5 6 -
  - r2: 7 8 9 *
  - r3: C 0 = /
- Reset values: ColOut=4'b1110, LFSRReset=0, KeyRdy=0, Number=0, Operator=000, EqualSign=0, state=SCAN. Reset mid-operation aborts and returns to SCAN.
- SCAN:
  - If RowIn==4'b1111, rotate ColOut one step per clock: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - If any RowIn bit is low, freeze ColOut, latch column and row (lowest-index low row wins if several), pulse LFSRReset for 1 cycle, and go to DB_PRESS.
- DB_PRESS:
  - ColOut held.
  - Ignore LFSRFlg in the cycle LFSRReset is high.
  - On the first later cycle with LFSRFlg=1: if the latched row is still low, decode into Number/Operator/EqualSign and go to WAIT_REL; otherwise go to SCAN with outputs unchanged.
- WAIT_REL:
  - ColOut held.
  - When RowIn==4'b1111, pulse LFSRReset for 1 cycle and go to DB_REL.
- DB_REL:
  - On the first LFSRFlg=1 after the pulse: if RowIn is still 4'b1111, set KeyRdy=1 and go to READY; otherwise return to WAIT_REL.
- READY:
  - Number, Operator, EqualSign and KeyRdy held stable. No scanning; ColOut stays on the latched column.
  - KeyRd=1 sampled -> KeyRdy=0 next cycle; go to SCAN, resuming rotation from the latched column.
  - Decoded outputs keep their last values until the next decode.
- KeyRd is ignored outside READY.
- Decode rules:
  - Exactly one of digit, operator or equals is meaningful per key.
  - Digit key: Operator=000, EqualSign=0.
  - Operator or clear key: Number=0, EqualSign=0.
  - '=': Number=0, Operator=000, EqualSign=1.
- Latency with LFSRFlg tied high:
  - press detected -> decoded 2 cycles later.
  - release seen -> KeyRdy 2 cycles later.
- LFSRReset is never high for more than one consecutive cycle.

Test Plan:
- Reset: Reset=1 for 1 cycle -> ColOut=1110, KeyRdy=0, Number=0, Operator=000, EqualSign=0, LFSRReset=0. With RowIn=1111, ColOut cycles 1101, 1011, 0111, 1110 on successive clocks.
- Digit key with LFSRFlg=1: hold RowIn=1110 while ColOut=1101, release after 3 cycles -> LFSRReset pulses on press and on release; KeyRdy=1 with Number=2, Operator=000, EqualSign=0. KeyRd=1 for 1 cycle -> KeyRdy=0 next cycle, scanning resumes.
- Operator and equals keys:
  - RowIn=1101 on column 0111 -> Operator=010 (sub), Number=0.
  - RowIn=0111 on column 1011 -> EqualSign=1.
  - RowIn=0111 on column 1110 -> Operator=101 (clear).
- Bounce on press: LFSRFlg=0, RowIn low for 1 cycle then 1111, then LFSRFlg=1 -> return to SCAN, KeyRdy stays 0, outputs unchanged.
- Bounce on release: key held, released, re-pressed before LFSRFlg, then finally released with LFSRFlg=1 -> exactly one KeyRdy assertion.
- Handshake and reset: KeyRd held low for 50 cycles in READY -> KeyRdy and outputs stable. Assert Reset in READY -> all outputs return to reset values the next cycle.
